// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the multi-cycle control unit.
//   - state_e      : FSM state encoding (also exported on the debug port)
//   - OP_*         : RV32 major opcodes recognised by the decoder
//   - ALU_*, SRCA_*, PC_*, RES_* : datapath select encodings
//   - cls_e        : registered opcode class
//   - alu_ctrl()   : per-class ALU control bundle, held from EXEC to retire
package control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_RTYPE  = 2'd2;
  localparam logic [1:0] ALU_IARITH = 2'd3;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_CSR = 2'd3;

  typedef enum logic [3:0] {
    CL_ILLEGAL, CL_R, CL_IARITH, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
    CL_JALR, CL_LUI, CL_AUIPC, CL_FARITH, CL_FLW, CL_FSW, CL_CSR
  } cls_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       falu_en;
  } alu_ctrl_t;

  function automatic alu_ctrl_t alu_ctrl(input cls_e c);
    alu_ctrl_t r;
    r = '0;
    case (c)
      CL_R:       r.alu_op = ALU_RTYPE;
      CL_IARITH: begin
        r.alu_op    = ALU_IARITH;
        r.alu_src_b = 1'b1;
      end
      CL_LOAD, CL_STORE, CL_FLW, CL_FSW, CL_JALR: r.alu_src_b = 1'b1;
      CL_BRANCH:  r.alu_op = ALU_SUB;
      CL_AUIPC: begin
        r.alu_src_a = SRCA_PC;
        r.alu_src_b = 1'b1;
      end
      CL_LUI: begin
        r.alu_src_a = SRCA_ZERO;
        r.alu_src_b = 1'b1;
      end
      CL_FARITH: begin
        r.alu_op  = ALU_RTYPE;
        r.falu_en = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode-to-class mapping.
//   opcode : IR[6:0]
//   cls    : instruction class (CL_ILLEGAL when not supported)
//   legal  : high when cls is a supported class
// Float and SYSTEM opcodes map to CL_ILLEGAL when their enable is 0.
module mc_decode
  import control_pkg::*;
#(
  parameter bit FLOAT_EN = 1'b1,
  parameter bit CSR_EN   = 1'b0
) (
  input  logic [6:0] opcode,
  output cls_e       cls,
  output logic       legal
);

  always_comb begin
    cls = CL_ILLEGAL;
    case (opcode)
      OP_R:      cls = CL_R;
      OP_IMM:    cls = CL_IARITH;
      OP_LOAD:   cls = CL_LOAD;
      OP_STORE:  cls = CL_STORE;
      OP_BRANCH: cls = CL_BRANCH;
      OP_JAL:    cls = CL_JAL;
      OP_JALR:   cls = CL_JALR;
      OP_LUI:    cls = CL_LUI;
      OP_AUIPC:  cls = CL_AUIPC;
      OP_FP:     if (FLOAT_EN) cls = CL_FARITH;
      OP_FLW:    if (FLOAT_EN) cls = CL_FLW;
      OP_FSW:    if (FLOAT_EN) cls = CL_FSW;
      OP_SYSTEM: if (CSR_EN)   cls = CL_CSR;
      default:   cls = CL_ILLEGAL;
    endcase
    legal = (cls != CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// instruction/data memory ready handshakes, illegal-opcode trap and a
// retired-instruction counter.
//   Inputs : clk, rst_n (async, active low), opcode, imem_ready,
//            dmem_ready, branch_taken, trap_ack
//   Outputs: memory requests, IR/PC/RF write enables, datapath selects,
//            illegal_insn, instret, state (debug)
// Outputs are decoded from the registered state and class; ir_write,
// store/branch retire and pc_src in EXEC also depend on the ready and
// branch inputs so they coincide with the handshake cycle.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter bit          FLOAT_EN = 1'b1,
  parameter bit          CSR_EN   = 1'b0,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  input  logic             trap_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       result_src,
  output logic             reg_write,
  output logic             freg_write,
  output logic             falu_en,
  output logic             csr_we,
  output logic             illegal_insn,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  state_e           state_q, state_d;
  cls_e             class_q, class_d;
  cls_e             dec_class;
  logic             dec_legal;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  alu_ctrl_t        ac;
  logic             is_mem, is_store, is_fp_wb;

  mc_decode #(
    .FLOAT_EN(FLOAT_EN),
    .CSR_EN  (CSR_EN)
  ) u_decode (
    .opcode(opcode),
    .cls   (dec_class),
    .legal (dec_legal)
  );

  assign ac       = alu_ctrl(class_q);
  assign is_store = (class_q == CL_STORE) || (class_q == CL_FSW);
  assign is_mem   = is_store || (class_q == CL_LOAD) || (class_q == CL_FLW);
  assign is_fp_wb = (class_q == CL_FARITH) || (class_q == CL_FLW);

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    retire       = 1'b0;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    alu_op       = ALU_ADD;
    alu_src_a    = SRCA_RS1;
    alu_src_b    = 1'b0;
    result_src   = RES_ALU;
    reg_write    = 1'b0;
    freg_write   = 1'b0;
    falu_en      = 1'b0;
    csr_we       = 1'b0;
    illegal_insn = 1'b0;

    // ALU controls are held through MEM and WB so the ALU result
    // register stays stable until the instruction retires.
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      {alu_op, alu_src_a, alu_src_b, falu_en} = ac;
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        state_d = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (class_q == CL_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = is_mem ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_write   = 1'b1;
        retire     = 1'b1;
        reg_write  = !is_fp_wb;
        freg_write = is_fp_wb;
        case (class_q)
          CL_LOAD, CL_FLW: result_src = RES_MEM;
          CL_JAL:  begin result_src = RES_PC4; pc_src = PC_IMM; end
          CL_JALR: begin result_src = RES_PC4; pc_src = PC_ALU; end
          CL_CSR:  begin result_src = RES_CSR; csr_we = 1'b1;   end
          default: ;
        endcase
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal_insn = 1'b1;
        if (trap_ack) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      class_q   <= CL_ILLEGAL;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. dut_a: floats and CSR enabled,
// 64-bit counter. dut_b: floats and CSR disabled, 4-bit counter.
module tb_multicycle_control_unit;
  import control_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [6:0]  a_opcode, b_opcode;
  logic        a_imem_ready, a_dmem_ready, a_taken, a_ack;
  logic        b_imem_ready, b_dmem_ready, b_taken, b_ack;
  logic        a_imem_req, a_ir_write, a_dmem_req, a_dmem_we, a_pc_write;
  logic        b_imem_req, b_ir_write, b_dmem_req, b_dmem_we, b_pc_write;
  logic [1:0]  a_pc_src, a_alu_op, a_alu_src_a, a_result_src;
  logic [1:0]  b_pc_src, b_alu_op, b_alu_src_a, b_result_src;
  logic        a_alu_src_b, a_reg_write, a_freg_write, a_falu_en, a_csr_we, a_illegal;
  logic        b_alu_src_b, b_reg_write, b_freg_write, b_falu_en, b_csr_we, b_illegal;
  logic [63:0] a_instret;
  logic [3:0]  b_instret;
  logic [2:0]  a_state, b_state;

  multicycle_control_unit #(.FLOAT_EN(1'b1), .CSR_EN(1'b1), .CNT_W(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(a_opcode), .imem_ready(a_imem_ready),
    .dmem_ready(a_dmem_ready), .branch_taken(a_taken), .trap_ack(a_ack),
    .imem_req(a_imem_req), .ir_write(a_ir_write), .dmem_req(a_dmem_req),
    .dmem_we(a_dmem_we), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .alu_op(a_alu_op), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .result_src(a_result_src), .reg_write(a_reg_write), .freg_write(a_freg_write),
    .falu_en(a_falu_en), .csr_we(a_csr_we), .illegal_insn(a_illegal),
    .instret(a_instret), .state(a_state));

  multicycle_control_unit #(.FLOAT_EN(1'b0), .CSR_EN(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(b_opcode), .imem_ready(b_imem_ready),
    .dmem_ready(b_dmem_ready), .branch_taken(b_taken), .trap_ack(b_ack),
    .imem_req(b_imem_req), .ir_write(b_ir_write), .dmem_req(b_dmem_req),
    .dmem_we(b_dmem_we), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .alu_op(b_alu_op), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .result_src(b_result_src), .reg_write(b_reg_write), .freg_write(b_freg_write),
    .falu_en(b_falu_en), .csr_we(b_csr_we), .illegal_insn(b_illegal),
    .instret(b_instret), .state(b_state));

  // Output bundles: illegal_insn is the LSB of *_all.
  logic [18:0] a_all, b_all;
  logic [5:0]  a_exec;
  logic [7:0]  a_ret;
  assign a_all = {a_imem_req, a_ir_write, a_dmem_req, a_dmem_we, a_pc_write, a_pc_src,
                  a_alu_op, a_alu_src_a, a_alu_src_b, a_result_src, a_reg_write,
                  a_freg_write, a_falu_en, a_csr_we, a_illegal};
  assign b_all = {b_imem_req, b_ir_write, b_dmem_req, b_dmem_we, b_pc_write, b_pc_src,
                  b_alu_op, b_alu_src_a, b_alu_src_b, b_result_src, b_reg_write,
                  b_freg_write, b_falu_en, b_csr_we, b_illegal};
  assign a_exec = {a_alu_op, a_alu_src_a, a_alu_src_b, a_falu_en};
  assign a_ret  = {a_reg_write, a_freg_write, a_result_src, a_pc_src, a_csr_we, a_dmem_we};

  typedef struct {
    logic [6:0]  op;
    logic        taken;
    int unsigned cycles;
    logic [1:0]  alu_op;
    logic [1:0]  src_a;
    logic        src_b;
    logic        falu;
    logic        rw;
    logic        frw;
    logic [1:0]  rsrc;
    logic [1:0]  psrc;
    logic        csr;
    logic        we;
    logic        trap;
  } vec_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [63:0] exp_a;
  logic [3:0]  exp_b;
  vec_t        sb[$];
  vec_t        vecs[15];

  function automatic vec_t mk(input logic [6:0] op, input logic tk, input int unsigned cyc,
                              input logic [1:0] aop, input logic [1:0] sa, input logic sbb,
                              input logic fa, input logic rw, input logic frw,
                              input logic [1:0] rs, input logic [1:0] ps, input logic csr,
                              input logic we, input logic trap);
    vec_t v;
    v.op = op; v.taken = tk; v.cycles = cyc; v.alu_op = aop; v.src_a = sa;
    v.src_b = sbb; v.falu = fa; v.rw = rw; v.frw = frw; v.rsrc = rs; v.psrc = ps;
    v.csr = csr; v.we = we; v.trap = trap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_a(input logic [2:0] s, input string name);
    int unsigned n;
    n = 0;
    while (a_state != s && n < 30) begin
      step();
      n++;
    end
    chk(name, 64'(a_state), 64'(s));
  endtask

  // Runs one instruction on dut_a with zero-wait memory; expected record
  // goes through the scoreboard and is checked when the DUT retires/traps.
  task automatic run_vec(input vec_t v, input int unsigned idx);
    vec_t        e;
    logic [5:0]  ex_got, hold_got;
    logic [7:0]  ret_got;
    logic [18:0] trap_all;
    int unsigned cyc, n;
    bit          done, trapped;
    a_opcode = v.op; a_taken = v.taken; a_imem_ready = 1'b1; a_dmem_ready = 1'b1;
    sb.push_back(v);
    #1;
    n = 0;
    while (a_state != S_FETCH && n < 20) begin step(); n++; end
    cyc = 0; done = 0; trapped = 0;
    ex_got = '0; hold_got = '0; ret_got = '0; trap_all = '0;
    while (!done && cyc < 30) begin
      cyc++;
      if (a_state == S_EXEC) ex_got = a_exec;
      if (a_pc_write) begin
        hold_got = a_exec; ret_got = a_ret; done = 1;
      end else if (a_state == S_TRAP) begin
        trap_all = a_all; trapped = 1; done = 1;
      end
      if (!done) step();
    end
    e = sb.pop_front();
    chk($sformatf("v%0d cycles", idx), 64'(cyc), 64'(e.cycles));
    chk($sformatf("v%0d trapped", idx), 64'(trapped), 64'(e.trap));
    if (e.trap) begin
      chk($sformatf("v%0d trap outputs", idx), 64'(trap_all), 64'(19'd1));
      a_ack = 1'b1;
      step();
      a_ack = 1'b0;
      chk($sformatf("v%0d trap_ack->FETCH", idx), 64'(a_state), 64'(S_FETCH));
      chk($sformatf("v%0d instret after trap", idx), a_instret, exp_a);
    end else begin
      chk($sformatf("v%0d exec ctrl", idx), 64'(ex_got),
          64'({e.alu_op, e.src_a, e.src_b, e.falu}));
      chk($sformatf("v%0d ctrl held at retire", idx), 64'(hold_got),
          64'({e.alu_op, e.src_a, e.src_b, e.falu}));
      chk($sformatf("v%0d retire outputs", idx), 64'(ret_got),
          64'({e.rw, e.frw, e.rsrc, e.psrc, e.csr, e.we}));
      exp_a = exp_a + 64'd1;
      step();
      chk($sformatf("v%0d instret", idx), a_instret, exp_a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  seq[5];
    int unsigned cyc, memcnt, req, ret;
    logic [1:0]  rsrc;
    bit          done;

    vecs[0]  = mk(OP_R,      1'b0, 4, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(OP_IMM,    1'b0, 4, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(OP_LOAD,   1'b0, 5, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(OP_STORE,  1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(OP_BRANCH, 1'b1, 3, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(OP_BRANCH, 1'b0, 3, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(OP_JAL,    1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(OP_JALR,   1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(OP_LUI,    1'b1, 4, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(OP_AUIPC,  1'b0, 4, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(OP_FP,     1'b0, 4, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(OP_FLW,    1'b0, 5, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(OP_FSW,    1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(OP_SYSTEM, 1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    vecs[14] = mk(7'b1111111, 1'b0, 3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    a_opcode = OP_R; a_imem_ready = 1'b1; a_dmem_ready = 1'b1; a_taken = 1'b0; a_ack = 1'b0;
    b_opcode = OP_R; b_imem_ready = 1'b0; b_dmem_ready = 1'b1; b_taken = 1'b0; b_ack = 1'b0;
    exp_a = '0; exp_b = '0;

    // Reset state, then add from reset release.
    step();
    chk("reset a outputs", 64'(a_all), 64'd0);
    chk("reset a state", 64'(a_state), 64'(S_IDLE));
    chk("reset a instret", a_instret, 64'd0);
    chk("reset b outputs", 64'(b_all), 64'd0);
    chk("reset b instret", 64'(b_instret), 64'd0);
    rst_n = 1'b1;
    seq[0] = S_FETCH; seq[1] = S_DECODE; seq[2] = S_EXEC; seq[3] = S_WB; seq[4] = S_FETCH;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("add state %0d", k), 64'(a_state), 64'(seq[k]));
      if (k == 3) chk("add WB reg_write", 64'(a_reg_write), 64'd1);
    end
    exp_a = 64'd1;
    chk("add instret after 5 cycles", a_instret, exp_a);

    for (int unsigned i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Two imem wait cycles on addi: total 6 cycles.
    a_opcode = OP_IMM; a_imem_ready = 1'b0;
    #1;
    wait_a(S_FETCH, "imem wait enter FETCH");
    chk("imem wait req/ir_write", 64'({a_imem_req, a_ir_write}), 64'(2'b10));
    step();
    chk("imem wait hold FETCH", 64'(a_state), 64'(S_FETCH));
    @(negedge clk);
    a_imem_ready = 1'b1;
    #1;
    chk("imem ready ir_write", 64'({a_imem_req, a_ir_write}), 64'(2'b11));
    cyc = 3;
    while (!a_pc_write && cyc < 30) begin step(); cyc++; end
    chk("imem wait total cycles", 64'(cyc), 64'd6);
    exp_a = exp_a + 64'd1;
    step();
    chk("imem wait instret", a_instret, exp_a);

    // lw with three dmem wait cycles: 8 cycles, dmem_req high for 4.
    a_opcode = OP_LOAD; a_dmem_ready = 1'b0;
    #1;
    wait_a(S_FETCH, "lw wait enter FETCH");
    cyc = 1; memcnt = 0; req = 0; rsrc = '0; done = 0;
    while (!done && cyc < 40) begin
      if (a_dmem_req) req++;
      if (a_pc_write) begin
        rsrc = a_result_src; done = 1;
      end else begin
        @(negedge clk);
        if (a_state == S_MEM) begin
          memcnt++;
          a_dmem_ready = (memcnt >= 4);
        end
        #1;
        cyc++;
      end
    end
    chk("lw wait total cycles", 64'(cyc), 64'd8);
    chk("lw wait dmem_req cycles", 64'(req), 64'd4);
    chk("lw wait WB result_src", 64'(rsrc), 64'(RES_MEM));
    exp_a = exp_a + 64'd1;
    step();
    chk("lw wait instret", a_instret, exp_a);

    // Reset asserted mid-MEM takes effect without a clock edge.
    a_opcode = OP_LOAD; a_dmem_ready = 1'b0;
    wait_a(S_MEM, "rst test enter MEM");
    step();
    chk("rst test dmem_req before", 64'(a_dmem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst outputs", 64'(a_all), 64'd0);
    chk("async rst state", 64'(a_state), 64'(S_IDLE));
    chk("async rst instret", a_instret, 64'd0);
    a_dmem_ready = 1'b1; a_imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_a = '0; exp_b = '0;
    #1;

    // dut_b: FLW is illegal with floats disabled.
    b_opcode = OP_FLW; b_imem_ready = 1'b1;
    cyc = 0;
    while (b_state != S_TRAP && cyc < 10) begin step(); cyc++; end
    chk("b flw reaches TRAP", 64'(b_state), 64'(S_TRAP));
    chk("b trap outputs", 64'(b_all), 64'(19'd1));
    chk("b trap instret", 64'(b_instret), 64'(exp_b));
    step();
    chk("b trap held without ack", 64'(b_state), 64'(S_TRAP));
    b_opcode = OP_R; b_ack = 1'b1;
    step();
    chk("b trap_ack->FETCH", 64'(b_state), 64'(S_FETCH));

    // 16 adds on the 4-bit counter wrap it to 0; trap_ack stays high
    // and must be ignored outside TRAP.
    cyc = 0; ret = 0;
    while (ret < 16 && cyc < 200) begin
      cyc++;
      if (b_pc_write) begin
        ret++;
        exp_b = exp_b + 4'd1;
      end
      if (ret < 16) step();
    end
    chk("b 16 adds cycles", 64'(cyc), 64'd64);
    step();
    chk("b instret model", 64'(b_instret), 64'(exp_b));
    chk("b instret wrapped", 64'(b_instret), 64'd0);
    b_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
